// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared FSM states and idle level for the 101 detector slice
package seq_det_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// rtl/seq_bit_serializer_if.sv - word input handshake of the bit serializer
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - double-buffered word to serial bit stream feeding the 101 detector
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT,
    parameter int   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_bit_serializer_if.slave  in_if,
    output logic                 d_out,
    output logic                 d_valid,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_sent
);

    localparam int            BW   = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [BW-1:0]    bit_cnt;
    logic             accept;
    logic             load_point;

    // Bit that leaves first from a word, depending on shift direction.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with the bit just sent discarded, next bit moved into the first position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready depends only on the hold register; reset forces it low immediately.
    assign in_if.in_ready = !hold_full && !rst;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign load_point     = (state == IDLE) || (bit_cnt == LAST);

    // Shifter FSM with hold register; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            d_out      <= IDLE_BIT;
            d_valid    <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else if (load_point) begin
            if (state == SHIFT) begin
                words_sent <= words_sent + CNT_W'(1);
            end
            if (hold_full) begin
                // Held word goes to the shifter; a word accepted now refills hold.
                shreg     <= hold;
                d_out     <= first_bit(hold);
                state     <= SHIFT;
                bit_cnt   <= '0;
                d_valid   <= 1'b1;
                busy      <= 1'b1;
                hold_full <= accept;
                if (accept) begin
                    hold <= in_if.in_data;
                end
            end else if (accept) begin
                // Bypass: hold is empty and the shifter loads this edge.
                shreg   <= in_if.in_data;
                d_out   <= first_bit(in_if.in_data);
                state   <= SHIFT;
                bit_cnt <= '0;
                d_valid <= 1'b1;
                busy    <= 1'b1;
            end else begin
                state   <= IDLE;
                bit_cnt <= '0;
                d_out   <= IDLE_BIT;
                d_valid <= 1'b0;
                busy    <= 1'b0;
            end
        end else begin
            bit_cnt <= bit_cnt + BW'(1);
            shreg   <= advance(shreg);
            d_out   <= first_bit(advance(shreg));
            busy    <= 1'b1;
            if (accept) begin
                hold      <= in_if.in_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb/tb_seq_bit_serializer.sv - bench for seq_bit_serializer against a bit-queue reference model
module tb_seq_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] drv_data;
    logic         drv_valid;

    logic         a_dout, a_valid, a_busy;
    logic [15:0]  a_sent;
    logic         b_dout, b_valid, b_busy;
    logic [3:0]   b_sent;

    int errors = 0;
    int checks = 0;

    bit qa[$];
    bit qb[$];
    int pops = 0;

    bit capture = 1'b0;
    bit cap[$];

    seq_bit_serializer_if #(.WIDTH(W)) a_if ();
    seq_bit_serializer_if #(.WIDTH(W)) b_if ();

    assign a_if.in_data  = drv_data;
    assign a_if.in_valid = drv_valid;
    assign b_if.in_data  = drv_data;
    assign b_if.in_valid = drv_valid;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_if      (a_if.slave),
        .d_out      (a_dout),
        .d_valid    (a_valid),
        .busy       (a_busy),
        .words_sent (a_sent)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_if      (b_if.slave),
        .d_out      (b_dout),
        .d_valid    (b_valid),
        .busy       (b_busy),
        .words_sent (b_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The hold slot is free when at most the word in flight remains queued.
    function automatic bit model_ready();
        return !rst && (qa.size() <= W);
    endfunction

    task automatic model_step();
        bit acc;
        acc = drv_valid && model_ready();
        if (rst) begin
            qa.delete();
            qb.delete();
            pops = 0;
        end else begin
            if (qa.size() > 0) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                pops++;
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qa.push_back(drv_data[W-1-i]);
                    qb.push_back(drv_data[i]);
                end
            end
        end
    endtask

    task automatic check_all();
        bit   has;
        int   words;
        has   = qa.size() > 0;
        words = pops / W;
        check("a_valid", 32'(a_valid), 32'(has));
        check("a_dout", 32'(a_dout), 32'(has ? qa[0] : 1'b0));
        check("a_busy", 32'(a_busy), 32'(has));
        check("a_ready", 32'(a_if.in_ready), 32'(model_ready()));
        check("a_words", 32'(a_sent), 32'(words % 65536));
        check("b_valid", 32'(b_valid), 32'(has));
        check("b_dout", 32'(b_dout), 32'(has ? qb[0] : 1'b0));
        check("b_busy", 32'(b_busy), 32'(has));
        check("b_ready", 32'(b_if.in_ready), 32'(model_ready()));
        check("b_words", 32'(b_sent), 32'(words % 16));
        if (capture && a_valid) cap.push_back(a_dout);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic send_word(input logic [W-1:0] w);
        bit acc;
        bit done;
        done      = 1'b0;
        drv_data  = w;
        drv_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            acc = model_ready();
            cycle();
            done = acc;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        drv_valid = 1'b0;
        drv_data  = W'($urandom);
    endtask

    initial begin
        int cnt;
        int pos;
        int i;

        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_data  = '0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Single word, MSB and LSB first in parallel.
        send_word(8'hA5);
        idle(10);
        check("t1_words", 32'(a_sent), 32'd1);

        // Back-to-back pair.
        send_word(8'hA5);
        send_word(8'h5A);
        idle(20);
        check("t2_words", 32'(a_sent), 32'd3);

        // LSB-first single set bit.
        send_word(8'h01);
        idle(10);

        // Reset after third bit.
        send_word(8'hFF);
        idle(2);
        rst = 1'b1;
        cycle();
        check("t4_dvalid", 32'(a_valid), 32'd0);
        check("t4_words", 32'(a_sent), 32'd0);
        rst = 1'b0;
        cycle();
        check("t4_ready", 32'(a_if.in_ready), 32'd1);

        // Three words offered while busy.
        send_word(8'hC3);
        send_word(8'h96);
        send_word(8'h3C);
        idle(30);
        check("t5_words", 32'(a_sent), 32'd3);

        // Stream into a non-overlapping 101 detector.
        cap.delete();
        capture = 1'b1;
        send_word(8'b1010_1000);
        idle(10);
        capture = 1'b0;
        cnt = 0;
        pos = -1;
        i   = 0;
        while (i + 2 < cap.size()) begin
            if (cap[i] && !cap[i+1] && cap[i+2]) begin
                if (cnt == 0) pos = i + 2;
                cnt++;
                i += 3;
            end else begin
                i++;
            end
        end
        check("t6_bits", 32'(cap.size()), 32'd8);
        check("t6_count", 32'(cnt), 32'd1);
        check("t6_pos", 32'(pos), 32'd2);

        // Random traffic with occasional reset.
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 149) == 0);
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_data  = W'($urandom);
            cycle();
        end
        rst       = 1'b0;
        drv_valid = 1'b0;
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
